spi_frame_receiver: RTL and testbench

Parametrised multi-channel SPI slave receiver for the audio front end. It is clocked directly by the SPI serial clock and deserialises MOSI into NUM_CHANNELS fixed-width slots per chip-select frame. It presents all channel words together at the end of each frame, with a toggle strobe for safe hand-off into the processing clock domain. It also flags frames aborted by chip-select deassertion.

---
 rtl/spi_frame_receiver_pkg.sv | 15 +
 rtl/spi_frame_receiver_if.sv | 24 ++
 rtl/spi_frame_receiver_slot_shifter.sv | 29 ++
 rtl/spi_frame_receiver.sv | 101 ++++++++++
 tb/tb_spi_frame_receiver.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/spi_frame_receiver_pkg.sv
// rtl/spi_frame_receiver_pkg.sv - shared types and defaults for the SPI frame receiver
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } rx_state_e;

    localparam int SPI_DATA_WIDTH    = 16;
    localparam int SPI_NUM_CHANNELS  = 2;
    localparam int SPI_SLOT_WIDTH    = 32;
    localparam int FRAME_COUNT_WIDTH = 8;

endpackage

// File: rtl/spi_frame_receiver_if.sv
// rtl/spi_frame_receiver_if.sv - serial input and frame output bundle of the receiver
interface spi_frame_receiver_if
    import spi_rx_pkg::*;
#(
    parameter int DATA_WIDTH   = SPI_DATA_WIDTH,
    parameter int NUM_CHANNELS = SPI_NUM_CHANNELS
);
    logic                               chip_select;
    logic                               mosi;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out;
    logic                               frame_toggle;
    logic [FRAME_COUNT_WIDTH-1:0]       frame_count;
    logic                               frame_error;

    modport master (
        output chip_select, mosi,
        input  data_out, frame_toggle, frame_count, frame_error
    );

    modport slave (
        input  chip_select, mosi,
        output data_out, frame_toggle, frame_count, frame_error
    );
endinterface

// File: rtl/spi_frame_receiver_slot_shifter.sv
// rtl/spi_frame_receiver_slot_shifter.sv - per-slot word deserialiser with selectable bit order
module spi_slot_shifter #(
    parameter int DATA_WIDTH = 16,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  serial_clk,
    input  logic                  shift_en,
    input  logic                  clear,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] word_next
);
    logic [DATA_WIDTH-1:0] shift_reg;

    // word_next already includes bit_in so the caller can capture the final bit on the same edge
    always_comb begin
        word_next = '0;
        if (MSB_FIRST)
            word_next = (shift_reg << 1) | DATA_WIDTH'(bit_in);
        else
            word_next = (shift_reg >> 1) | (DATA_WIDTH'(bit_in) << (DATA_WIDTH - 1));
    end

    always_ff @(posedge serial_clk) begin
        if (clear)
            shift_reg <= '0;
        else if (shift_en)
            shift_reg <= word_next;
    end
endmodule

// File: rtl/spi_frame_receiver.sv
// rtl/spi_frame_receiver.sv - multi-channel SPI slave frame receiver with toggle hand-off strobe
module spi_frame_receiver
    import spi_rx_pkg::*;
#(
    parameter int DATA_WIDTH   = SPI_DATA_WIDTH,
    parameter int NUM_CHANNELS = SPI_NUM_CHANNELS,
    parameter int SLOT_WIDTH   = SPI_SLOT_WIDTH,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                 serial_clk,
    input  logic                 reset,
    spi_frame_receiver_if.slave  bus
);
    localparam int BIT_W  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int SLOT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [BIT_W-1:0]  LAST_DATA_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  LAST_SLOT_BIT = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT     = SLOT_W'(NUM_CHANNELS - 1);

    generate
        if (SLOT_WIDTH < DATA_WIDTH) begin : g_bad_slot
            $error("spi_frame_receiver: SLOT_WIDTH must be >= DATA_WIDTH");
        end
    endgenerate

    rx_state_e             state;
    logic [BIT_W-1:0]      bit_idx;
    logic [SLOT_W-1:0]     slot_idx;
    logic [DATA_WIDTH-1:0] staging [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] word_next;
    logic                  shift_en;
    logic                  shift_clear;
    logic                  word_done;
    logic                  slot_end;
    logic                  frame_end;

    assign shift_en    = !reset && !bus.chip_select && (state != PAD);
    assign shift_clear = reset || bus.chip_select;
    assign word_done   = shift_en && (bit_idx == LAST_DATA_BIT);
    assign slot_end    = (bit_idx == LAST_SLOT_BIT);
    assign frame_end   = slot_end && (slot_idx == LAST_SLOT);

    spi_slot_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shifter (
        .serial_clk (serial_clk),
        .shift_en   (shift_en),
        .clear      (shift_clear),
        .bit_in     (bus.mosi),
        .word_next  (word_next)
    );

    always_ff @(posedge serial_clk) begin
        if (reset) begin
            state            <= IDLE;
            bit_idx          <= '0;
            slot_idx         <= '0;
            bus.data_out     <= '0;
            bus.frame_toggle <= 1'b0;
            bus.frame_count  <= '0;
            bus.frame_error  <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) staging[c] <= '0;
        end else if (bus.chip_select) begin
            // Deselect on a frame boundary is a clean idle; anywhere else the frame is lost
            if (bit_idx != '0 || slot_idx != '0)
                bus.frame_error <= 1'b1;
            state    <= IDLE;
            bit_idx  <= '0;
            slot_idx <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) staging[c] <= '0;
        end else begin
            if (word_done)
                staging[slot_idx] <= word_next;

            if (slot_end) begin
                bit_idx <= '0;
                state   <= DATA;
                if (frame_end) begin
                    slot_idx <= '0;
                    for (int c = 0; c < NUM_CHANNELS; c++) begin
                        if (c == NUM_CHANNELS - 1 && word_done)
                            bus.data_out[c*DATA_WIDTH +: DATA_WIDTH] <= word_next;
                        else
                            bus.data_out[c*DATA_WIDTH +: DATA_WIDTH] <= staging[c];
                    end
                    bus.frame_toggle <= ~bus.frame_toggle;
                    bus.frame_count  <= bus.frame_count + 1'b1;
                end else begin
                    slot_idx <= slot_idx + SLOT_W'(1);
                end
            end else begin
                bit_idx <= bit_idx + BIT_W'(1);
                if (word_done)
                    state <= PAD;
                else if (state == IDLE)
                    state <= DATA;
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb/tb_spi_frame_receiver.sv - directed self-checking bench for spi_frame_receiver
module tb_spi_frame_receiver;
    import spi_rx_pkg::*;

    logic serial_clk = 1'b0;
    logic reset      = 1'b1;
    int   total      = 0;
    int   bad        = 0;
    bit   stable_ok;

    always #5 serial_clk = ~serial_clk;

    spi_frame_receiver_if #(.DATA_WIDTH(16), .NUM_CHANNELS(2)) a_if ();
    spi_frame_receiver_if #(.DATA_WIDTH(16), .NUM_CHANNELS(2)) b_if ();

    spi_frame_receiver #(
        .DATA_WIDTH(16), .NUM_CHANNELS(2), .SLOT_WIDTH(32), .MSB_FIRST(1'b1)
    ) dut_a (
        .serial_clk (serial_clk),
        .reset      (reset),
        .bus        (a_if.slave)
    );

    spi_frame_receiver #(
        .DATA_WIDTH(16), .NUM_CHANNELS(2), .SLOT_WIDTH(16), .MSB_FIRST(1'b0)
    ) dut_b (
        .serial_clk (serial_clk),
        .reset      (reset),
        .bus        (b_if.slave)
    );

    task automatic tick();
        @(posedge serial_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // 32-bit slots, MSB first, padding driven high
    task automatic frame_a(input logic [15:0] c0, input logic [15:0] c1);
        logic [31:0] snap;
        logic [15:0] w;
        int p;
        snap = a_if.data_out;
        stable_ok = 1'b1;
        for (int k = 0; k < 64; k++) begin
            w = (k < 32) ? c0 : c1;
            p = k % 32;
            a_if.chip_select = 1'b0;
            a_if.mosi = (p < 16) ? w[15-p] : 1'b1;
            tick();
            if (k < 63 && a_if.data_out !== snap) stable_ok = 1'b0;
        end
    endtask

    // 16-bit slots with no padding, LSB first
    task automatic frame_b(input logic [15:0] c0, input logic [15:0] c1);
        logic [15:0] w;
        for (int k = 0; k < 32; k++) begin
            w = (k < 16) ? c0 : c1;
            b_if.chip_select = 1'b0;
            b_if.mosi = w[k%16];
            tick();
        end
    endtask

    initial begin
        a_if.chip_select = 1'b0;
        a_if.mosi        = 1'b1;
        b_if.chip_select = 1'b0;
        b_if.mosi        = 1'b1;

        // reset wins over an active chip select
        repeat (3) tick();
        chk("rst_a_data",   64'(a_if.data_out),     64'h0);
        chk("rst_a_toggle", 64'(a_if.frame_toggle), 64'h0);
        chk("rst_a_count",  64'(a_if.frame_count),  64'h0);
        chk("rst_a_error",  64'(a_if.frame_error),  64'h0);
        chk("rst_b_data",   64'(b_if.data_out),     64'h0);
        chk("rst_b_count",  64'(b_if.frame_count),  64'h0);
        reset = 1'b0;
        b_if.chip_select = 1'b1;

        frame_a(16'hA5C3, 16'h1234);
        chk("f1_stable", 64'(stable_ok),         64'h1);
        chk("f1_data",   64'(a_if.data_out),     64'h1234_A5C3);
        chk("f1_toggle", 64'(a_if.frame_toggle), 64'h1);
        chk("f1_count",  64'(a_if.frame_count),  64'h1);
        chk("f1_error",  64'(a_if.frame_error),  64'h0);

        frame_a(16'h0001, 16'hFFFF);
        chk("f2_stable", 64'(stable_ok),         64'h1);
        chk("f2_data",   64'(a_if.data_out),     64'hFFFF_0001);
        chk("f2_toggle", 64'(a_if.frame_toggle), 64'h0);
        chk("f2_count",  64'(a_if.frame_count),  64'h2);

        for (int k = 0; k < 20; k++) begin
            a_if.mosi = k[0];
            tick();
        end
        a_if.chip_select = 1'b1;
        tick();
        chk("abort_error",  64'(a_if.frame_error),  64'h1);
        chk("abort_data",   64'(a_if.data_out),     64'hFFFF_0001);
        chk("abort_count",  64'(a_if.frame_count),  64'h2);
        chk("abort_toggle", 64'(a_if.frame_toggle), 64'h0);

        frame_a(16'hBEEF, 16'hCAFE);
        chk("f3_data",   64'(a_if.data_out),     64'hCAFE_BEEF);
        chk("f3_count",  64'(a_if.frame_count),  64'h3);
        chk("f3_error",  64'(a_if.frame_error),  64'h1);
        chk("f3_toggle", 64'(a_if.frame_toggle), 64'h1);

        a_if.chip_select = 1'b0;
        for (int k = 0; k < 40; k++) begin
            a_if.mosi = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_count", 64'(a_if.frame_count), 64'h0);
        chk("midrst_error", 64'(a_if.frame_error), 64'h0);
        frame_a(16'h1111, 16'h2222);
        chk("f4_data",  64'(a_if.data_out),    64'h2222_1111);
        chk("f4_count", 64'(a_if.frame_count), 64'h1);
        chk("f4_error", 64'(a_if.frame_error), 64'h0);

        // deselect on a frame boundary must not flag an error
        a_if.chip_select = 1'b1;
        repeat (2) tick();
        chk("idle_error", 64'(a_if.frame_error), 64'h0);
        chk("idle_data",  64'(a_if.data_out),    64'h2222_1111);

        b_if.chip_select = 1'b1;
        tick();
        frame_b(16'hA5C3, 16'h8001);
        chk("b1_data",   64'(b_if.data_out),     64'h8001_A5C3);
        chk("b1_count",  64'(b_if.frame_count),  64'h1);
        chk("b1_toggle", 64'(b_if.frame_toggle), 64'h1);
        chk("b1_error",  64'(b_if.frame_error),  64'h0);

        for (int n = 0; n < 254; n++) frame_b(16'(n), 16'(~n));
        chk("b255_count", 64'(b_if.frame_count), 64'hFF);
        chk("b255_data",  64'(b_if.data_out),    64'h FF02_00FD);
        frame_b(16'h0F0F, 16'h7E81);
        chk("bwrap_count",  64'(b_if.frame_count),  64'h0);
        chk("bwrap_toggle", 64'(b_if.frame_toggle), 64'h0);
        chk("bwrap_data",   64'(b_if.data_out),     64'h7E81_0F0F);
        chk("bwrap_error",  64'(b_if.frame_error),  64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
